// File: rtl/ysyx_22040088_mdu_pkg.sv
// ysyx_22040088_mdu_pkg: op encoding, FSM states and op-class helpers for the MDU
package ysyx_22040088_mdu_pkg;
  localparam logic [3:0] MUL    = 4'd0;
  localparam logic [3:0] MULH   = 4'd1;
  localparam logic [3:0] MULHSU = 4'd2;
  localparam logic [3:0] MULHU  = 4'd3;
  localparam logic [3:0] DIV    = 4'd4;
  localparam logic [3:0] DIVU   = 4'd5;
  localparam logic [3:0] REM    = 4'd6;
  localparam logic [3:0] REMU   = 4'd7;
  localparam logic [3:0] MULW   = 4'd8;
  localparam logic [3:0] DIVW   = 4'd9;
  localparam logic [3:0] DIVUW  = 4'd10;
  localparam logic [3:0] REMW   = 4'd11;
  localparam logic [3:0] REMUW  = 4'd12;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic is_w(input logic [3:0] op);
    return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
  endfunction

  function automatic logic is_rem(input logic [3:0] op);
    return op inside {REM, REMU, REMW, REMUW};
  endfunction

  // src2 signedness; src1 is additionally signed for MULHSU
  function automatic logic is_signed(input logic [3:0] op);
    return op inside {MULH, DIV, REM, MULW, DIVW, REMW};
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > REMUW;
  endfunction
endpackage

// File: rtl/ysyx_22040088_mdu_step.sv
// ysyx_22040088_mdu_step: one combinational shift-add or restoring trial-subtract iteration
module ysyx_22040088_mdu_step #(
  parameter int XLEN = 64
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [2*XLEN-1:0] a_o,
  output logic [XLEN-1:0]   b_o
);
  logic [XLEN:0] r_sh, d, r_n;
  logic ge;
  // divide: acc holds the partial remainder, b shifts dividend out and quotient in
  assign r_sh = {acc_i[XLEN-1:0], b_i[XLEN-1]};
  assign d = {1'b0, a_i[XLEN-1:0]};
  assign ge = r_sh >= d;
  assign r_n = ge ? r_sh - d : r_sh;
  assign acc_o = div_i ? {{(XLEN-1){1'b0}}, r_n} : (b_i[0] ? acc_i + a_i : acc_i);
  assign a_o = div_i ? a_i : a_i << 1;
  assign b_o = div_i ? {b_i[XLEN-2:0], ge} : b_i >> 1;
endmodule

// File: rtl/ysyx_22040088_mdu_ctrl.sv
// ysyx_22040088_mdu_ctrl: iterative RV64M multiply/divide with valid/ready sequencing
module ysyx_22040088_mdu_ctrl
  import ysyx_22040088_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);
  localparam int H = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2*XLEN-1:0] acc_q, a_q, acc_n, a_n, prod_s;
  logic [XLEN-1:0] b_q, b_n, res_q;
  logic [3:0] op_q;
  logic negq_q, negr_q;
  logic w, sg1, sg2, n1, n2, dv, dz, ovf, spec;
  logic [XLEN-1:0] x1, x2, m1, m2, min_v, sres, q_s, r_s, fres;

  function automatic logic [XLEN-1:0] fin(input logic wop, input logic [XLEN-1:0] v);
    return wop ? {{H{v[H-1]}}, v[H-1:0]} : v;
  endfunction

  assign in_ready = (state_q == IDLE) & ~flush & ~rst;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_result = res_q;

  assign w = is_w(in_op);
  assign sg2 = is_signed(in_op);
  assign sg1 = sg2 | (in_op == MULHSU);
  assign x1 = w ? {{H{sg1 & in_src1[H-1]}}, in_src1[H-1:0]} : in_src1;
  assign x2 = w ? {{H{sg2 & in_src2[H-1]}}, in_src2[H-1:0]} : in_src2;
  assign n1 = sg1 & x1[XLEN-1];
  assign n2 = sg2 & x2[XLEN-1];
  assign m1 = n1 ? -x1 : x1;
  assign m2 = n2 ? -x2 : x2;
  // most negative value at the op width, already sign-extended to XLEN
  assign min_v = w ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign dv = is_div(in_op);
  assign dz = dv & (x2 == '0);
  assign ovf = dv & sg2 & (x1 == min_v) & (&x2);
  assign spec = dz | ovf | is_illegal(in_op);
  assign sres = is_illegal(in_op) ? '0 :
                fin(w, dz ? (is_rem(in_op) ? x1 : '1) : (is_rem(in_op) ? '0 : min_v));

  ysyx_22040088_mdu_step #(.XLEN(XLEN)) u_step (
    .div_i(is_div(op_q)),
    .acc_i(acc_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .acc_o(acc_n),
    .a_o  (a_n),
    .b_o  (b_n)
  );

  // sign fixup applied to the final iteration's outputs
  assign prod_s = negq_q ? -acc_n : acc_n;
  assign q_s = negq_q ? -b_n : b_n;
  assign r_s = negr_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
  assign fres = fin(is_w(op_q), is_div(op_q) ? (is_rem(op_q) ? r_s : q_s) :
                ((op_q == MUL || op_q == MULW) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      res_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= in_op;
          acc_q <= '0;
          negq_q <= n1 ^ n2;
          negr_q <= n1;
          cnt_q <= w ? CW'(H - 1) : CW'(XLEN - 1);
          a_q <= {{XLEN{1'b0}}, dv ? m2 : m1};
          b_q <= dv ? (w ? m1 << H : m1) : m2;
          res_q <= spec ? sres : res_q;
          state_q <= spec ? DONE : BUSY;
        end
        BUSY: begin
          acc_q <= acc_n;
          a_q <= a_n;
          b_q <= b_n;
          cnt_q <= (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
          res_q <= (cnt_q == '0) ? fres : res_q;
          state_q <= (cnt_q == '0) ? DONE : BUSY;
        end
        DONE: state_q <= out_ready ? IDLE : DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22040088_mdu_ctrl.sv
// tb_ysyx_22040088_mdu_ctrl: directed vectors with hand-computed results and latencies
module tb_ysyx_22040088_mdu_ctrl;
  import ysyx_22040088_mdu_pkg::*;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [3:0] in_op = 0;
  logic [63:0] in_src1 = 0, in_src2 = 0, out_result;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ysyx_22040088_mdu_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] s1, input logic [63:0] s2);
    @(negedge clk);
    in_valid = 1; in_op = op; in_src1 = s1; in_src2 = s2;
    @(posedge clk);
    #1 in_valid = 0; in_op = 4'd15; in_src1 = 64'hDEAD_BEEF_0BAD_F00D; in_src2 = 64'h1234_5678_9ABC_DEF0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [63:0] s1,
                     input logic [63:0] s2, input logic [63:0] exp, input int elat);
    int lat;
    issue(op, s1, s2);
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk(tag, out_result, exp);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  initial begin
    int lat, hits;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", out_result, 64'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    run("mul", MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run("mulhu", MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("mulh", MULH, '1, '1, 64'd0, 65);
    run("mulhsu", MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("div0", DIV, 64'd100, 64'd0, '1, 1);
    run("rem0", REM, 64'd100, 64'd0, 64'd100, 1);
    run("div_ovf", DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run("rem_ovf", REM, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run("rem_neg", REM, -64'sd7, 64'd2, '1, 65);
    run("div_neg", DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("divu", DIVU, 64'd100, 64'd7, 64'd14, 65);
    run("remu", REMU, 64'd100, 64'd7, 64'd2, 65);
    run("divuw", DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run("remw_ovf", REMW, 64'h0000_0000_8000_0000, '1, 64'd0, 1);
    run("mulw_wrap", MULW, 64'h1_0000, 64'h1_0000, 64'd0, 33);
    run("mulw_neg", MULW, 64'd3, 64'h0000_0000_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 33);
    run("divw_neg", DIVW, 64'hAAAA_0000_FFFF_FFF8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run("remuw", REMUW, 64'h0000_0000_F000_0000, 64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0000, 33);
    run("divw0", DIVW, 64'd5, 64'hFFFF_FFFF_0000_0000, '1, 1);
    run("illegal", 4'd13, 64'd9, 64'd9, 64'd0, 1);

    issue(MUL, 64'd6, 64'd7);
    wait_valid(lat);
    chk("bp_lat", 64'(lat), 64'd65);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", out_result, 64'd42);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("bp_release", 64'(in_ready), 64'd1);

    issue(DIV, 64'd1000, 64'd3);
    repeat (9) @(negedge clk);
    in_valid = 1; in_op = MUL; in_src1 = 64'd1; in_src2 = 64'd1; flush = 1;
    @(posedge clk);
    #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    hits = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("flush_no_valid", 64'(hits), 64'd0);
    run("after_flush", DIV, 64'd1000, 64'd3, 64'd333, 65);

    issue(REMU, 64'd10, 64'd0);
    @(negedge clk);
    chk("fd_valid_pre", 64'(out_valid), 64'd1);
    flush = 1; out_ready = 1;
    @(posedge clk);
    #1 flush = 0; out_ready = 0;
    @(negedge clk);
    chk("fd_valid", 64'(out_valid), 64'd0);
    chk("fd_busy", 64'(busy), 64'd0);
    run("final", MULW, 64'd4, 64'd5, 64'd20, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
